// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: data-memory handshake, pipeline stall, load byte extraction and MEM/WB register.
// Define MEM_STAGE_TIMEOUT_EN to abort accesses unacknowledged for 255 cycles and raise a sticky memError.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] regData2In,
  input  logic [31:0] aluResultIn,
  input  logic [4:0]  writeRegIn,
  input  logic        regWriteIn,
  input  logic        memToRegIn,
  input  logic        memWriteIn,
  input  logic        memReadIn,
  input  logic        loadFullWordIn,
  input  logic        loadSignedIn,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic        stall,
  output logic        wbRegWriteOut,
  output logic        wbMemToRegOut,
  output logic [31:0] wbMemDataOut,
  output logic [31:0] wbAluResultOut,
  output logic [4:0]  wbWriteRegOut,
  output logic        memError
);

  typedef enum logic {IDLE, WAIT} stateT;

  stateT       state;
  logic        memOp;
  logic        reqRaw;
  logic        timeoutHit;
  logic        accessDone;
  logic [7:0]  selByte;
  logic [31:0] loadData;

  assign memOp = memReadIn | memWriteIn;

  // Reset gates the request directly so an abandoned access drops without waiting for a clock.
  assign reqRaw     = ~reset & ((state == WAIT) | memOp);
  assign memReq     = reqRaw & ~timeoutHit;
  assign stall      = memReq & ~memAck;
  assign accessDone = memReq & memAck;
  assign memWe      = memWriteIn;
  assign memAddr    = aluResultIn;
  assign memWData   = regData2In;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [7:0] timeoutCnt;

  assign timeoutHit = (timeoutCnt == 8'hFF);

  // Counts consecutive unacknowledged request cycles; the 256th cycle aborts the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeoutCnt <= 8'd0;
      memError   <= 1'b0;
    end else if (timeoutHit) begin
      timeoutCnt <= 8'd0;
      memError   <= 1'b1;
    end else if (stall) begin
      timeoutCnt <= timeoutCnt + 8'd1;
    end else begin
      timeoutCnt <= 8'd0;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign memError   = 1'b0;
`endif

  always_comb begin
    selByte  = memRData[7:0];
    loadData = memRData;
    case (aluResultIn[1:0])
      2'd0: selByte = memRData[7:0];
      2'd1: selByte = memRData[15:8];
      2'd2: selByte = memRData[23:16];
      2'd3: selByte = memRData[31:24];
      default: selByte = memRData[7:0];
    endcase
    if (!loadFullWordIn) begin
      if (loadSignedIn)
        loadData = {{24{selByte[7]}}, selByte};
      else
        loadData = {24'd0, selByte};
    end
  end

  // While stalled or aborting, only the write-enable bits are cleared so WB sees a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wbRegWriteOut  <= 1'b0;
      wbMemToRegOut  <= 1'b0;
      wbMemDataOut   <= 32'd0;
      wbAluResultOut <= 32'd0;
      wbWriteRegOut  <= 5'd0;
    end else begin
      case (state)
        IDLE:    if (stall) state <= WAIT;
        WAIT:    if (accessDone || timeoutHit) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (stall || timeoutHit) begin
        wbRegWriteOut <= 1'b0;
        wbMemToRegOut <= 1'b0;
      end else begin
        wbRegWriteOut  <= regWriteIn;
        wbMemToRegOut  <= memToRegIn;
        wbAluResultOut <= aluResultIn;
        wbWriteRegOut  <= writeRegIn;
        if (accessDone && memReadIn && !memWriteIn)
          wbMemDataOut <= loadData;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table with a WB scoreboard plus reset, ack-ignore and timeout sequences.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] regData2In, aluResultIn;
  logic [4:0]  writeRegIn;
  logic        regWriteIn, memToRegIn, memWriteIn, memReadIn, loadFullWordIn, loadSignedIn;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWData;
  logic        memAck;
  logic [31:0] memRData;
  logic        stall;
  logic        wbRegWriteOut, wbMemToRegOut;
  logic [31:0] wbMemDataOut, wbAluResultOut;
  logic [4:0]  wbWriteRegOut;
  logic        memError;

  typedef struct {
    logic        memRead;
    logic        memWrite;
    logic        loadFull;
    logic        loadSigned;
    logic        regWrite;
    logic        memToReg;
    logic [31:0] alu;
    logic [31:0] data2;
    logic [31:0] rdata;
    logic [4:0]  wreg;
    int          ackDelay;
    logic [31:0] expMemData;
  } vecT;

  typedef struct {
    logic        regWrite;
    logic        memToReg;
    logic [31:0] memData;
    logic [31:0] alu;
    logic [4:0]  wreg;
  } wbT;

  vecT vecs[10];
  wbT  expQ[$];
  int  checkCount = 0;
  int  passCount  = 0;

  mem_stage_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .regData2In     (regData2In),
    .aluResultIn    (aluResultIn),
    .writeRegIn     (writeRegIn),
    .regWriteIn     (regWriteIn),
    .memToRegIn     (memToRegIn),
    .memWriteIn     (memWriteIn),
    .memReadIn      (memReadIn),
    .loadFullWordIn (loadFullWordIn),
    .loadSignedIn   (loadSignedIn),
    .memReq         (memReq),
    .memWe          (memWe),
    .memAddr        (memAddr),
    .memWData       (memWData),
    .memAck         (memAck),
    .memRData       (memRData),
    .stall          (stall),
    .wbRegWriteOut  (wbRegWriteOut),
    .wbMemToRegOut  (wbMemToRegOut),
    .wbMemDataOut   (wbMemDataOut),
    .wbAluResultOut (wbAluResultOut),
    .wbWriteRegOut  (wbWriteRegOut),
    .memError       (memError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input vecT v);
    memReadIn      = v.memRead;
    memWriteIn     = v.memWrite;
    loadFullWordIn = v.loadFull;
    loadSignedIn   = v.loadSigned;
    regWriteIn     = v.regWrite;
    memToRegIn     = v.memToReg;
    aluResultIn    = v.alu;
    regData2In     = v.data2;
    writeRegIn     = v.wreg;
    memAck         = 1'b0;
    memRData       = 32'd0;
  endtask

  task automatic checkOutput(input string tag);
    wbT e;
    if (expQ.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      check({tag, " wbRegWrite"}, {31'd0, wbRegWriteOut}, {31'd0, e.regWrite});
      check({tag, " wbMemToReg"}, {31'd0, wbMemToRegOut}, {31'd0, e.memToReg});
      check({tag, " wbMemData"}, wbMemDataOut, e.memData);
      check({tag, " wbAluResult"}, wbAluResultOut, e.alu);
      check({tag, " wbWriteReg"}, {27'd0, wbWriteRegOut}, {27'd0, e.wreg});
    end
  endtask

  function automatic wbT makeExp(input vecT v);
    wbT e;
    e.regWrite = v.regWrite;
    e.memToReg = v.memToReg;
    e.memData  = v.expMemData;
    e.alu      = v.alu;
    e.wreg     = v.wreg;
    return e;
  endfunction

  initial begin
    logic [31:0] prevAlu;
    int          stallCycles;
    vecT         v;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000004, 32'h0, 32'h0, 5'd5, 0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000100, 32'h0, 32'hDEADBEEF, 5'd8, 3, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000101, 32'h0, 32'h000080FF, 5'd9, 0, 32'hFFFFFF80};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000101, 32'h0, 32'h000080FF, 5'd10, 1, 32'h00000080};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000200, 32'h12345678, 32'hFFFFFFFF, 5'd0, 0, 32'h00000080};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000003, 32'h0, 32'h7F000000, 5'd11, 2, 32'h0000007F};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h0, 32'hAABBCCFE, 5'd12, 0, 32'h000000FE};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000012, 32'h0, 32'h00F00000, 5'd13, 1, 32'hFFFFFFF0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 32'h0, 5'd31, 0, 32'hFFFFFFF0};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000300, 32'hA5A5A5A5, 32'h11111111, 5'd0, 1, 32'hFFFFFFF0};

    reset = 1'b1;
    applyStimulus(vecs[0]);
    memReadIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset wbRegWrite", {31'd0, wbRegWriteOut}, 32'd0);
    check("reset wbAluResult", wbAluResultOut, 32'd0);
    check("reset memReq", {31'd0, memReq}, 32'd0);
    check("reset memError", {31'd0, memError}, 32'd0);
    reset = 1'b0;

    // Table-driven vectors; each memory op holds ackDelay stall cycles before the ack.
    prevAlu = 32'd0;
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      applyStimulus(v);
      expQ.push_back(makeExp(v));
      if (v.memRead || v.memWrite) begin
        stallCycles = 0;
        for (int c = 0; c < v.ackDelay; c++) begin
          #1;
          if (stall) stallCycles++;
          check($sformatf("v%0d memReq wait", i), {31'd0, memReq}, 32'd1);
          @(posedge clk);
          #1;
          check($sformatf("v%0d bubble regWrite", i), {31'd0, wbRegWriteOut}, 32'd0);
          check($sformatf("v%0d bubble memToReg", i), {31'd0, wbMemToRegOut}, 32'd0);
          check($sformatf("v%0d bubble alu", i), wbAluResultOut, prevAlu);
        end
        check($sformatf("v%0d stall cycles", i), stallCycles, v.ackDelay);
        memAck   = 1'b1;
        memRData = v.rdata;
        #1;
        check($sformatf("v%0d stall at ack", i), {31'd0, stall}, 32'd0);
        check($sformatf("v%0d memReq at ack", i), {31'd0, memReq}, 32'd1);
        check($sformatf("v%0d memWe", i), {31'd0, memWe}, {31'd0, v.memWrite});
        check($sformatf("v%0d memAddr", i), memAddr, v.alu);
        if (v.memWrite)
          check($sformatf("v%0d memWData", i), memWData, v.data2);
        @(posedge clk);
        #1;
        memAck = 1'b0;
      end else begin
        #1;
        check($sformatf("v%0d stall", i), {31'd0, stall}, 32'd0);
        check($sformatf("v%0d memReq", i), {31'd0, memReq}, 32'd0);
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("v%0d", i));
      prevAlu = v.alu;
    end

    // An ack with no request outstanding must not disturb the next access.
    v = vecs[0];
    v.alu = 32'h00000044;
    v.expMemData = 32'hFFFFFFF0;
    applyStimulus(v);
    memAck   = 1'b1;
    memRData = 32'h99999999;
    expQ.push_back(makeExp(v));
    @(posedge clk);
    #1;
    checkOutput("stray ack");
    applyStimulus(vecs[1]);
    #1;
    check("post stray stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    memAck   = 1'b1;
    memRData = 32'h01020304;
    v = vecs[1];
    v.expMemData = 32'h01020304;
    expQ.push_back(makeExp(v));
    @(posedge clk);
    #1;
    memAck = 1'b0;
    checkOutput("post stray load");

    // Reset asserted mid-WAIT, then released with the load still presented.
    v = vecs[1];
    v.alu  = 32'h00000040;
    v.wreg = 5'd3;
    applyStimulus(v);
    repeat (2) @(posedge clk);
    #3;
    check("pre-reset stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("midwait memReq", {31'd0, memReq}, 32'd0);
    check("midwait stall", {31'd0, stall}, 32'd0);
    check("midwait wbMemData", wbMemDataOut, 32'd0);
    check("midwait wbAluResult", wbAluResultOut, 32'd0);
    check("midwait wbWriteReg", {27'd0, wbWriteRegOut}, 32'd0);
    check("midwait wbMemToReg", {31'd0, wbMemToRegOut}, 32'd0);
    check("midwait memError", {31'd0, memError}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("restart memReq", {31'd0, memReq}, 32'd1);
    check("restart stall", {31'd0, stall}, 32'd1);
    memAck   = 1'b1;
    memRData = 32'h0BADF00D;
    v.expMemData = 32'h0BADF00D;
    expQ.push_back(makeExp(v));
    @(posedge clk);
    #1;
    memAck = 1'b0;
    checkOutput("restart");

    // Never-acknowledged load: timeout build aborts after 255 stall cycles.
    applyStimulus(vecs[1]);
    stallCycles = 0;
    #1;
    for (int c = 0; c < 300; c++) begin
      if (!stall) break;
      stallCycles++;
      @(posedge clk);
      #1;
    end
`ifdef MEM_STAGE_TIMEOUT_EN
    check("timeout stall cycles", stallCycles, 32'd255);
    check("timeout memReq", {31'd0, memReq}, 32'd0);
    @(posedge clk);
    #1;
    check("timeout memError", {31'd0, memError}, 32'd1);
    check("timeout bubble", {31'd0, wbRegWriteOut}, 32'd0);
    memReadIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("timeout memError sticky", {31'd0, memError}, 32'd1);
    check("timeout idle memReq", {31'd0, memReq}, 32'd0);
`else
    check("no-timeout stall cycles", stallCycles, 32'd300);
    check("no-timeout memError", {31'd0, memError}, 32'd0);
    check("no-timeout memReq", {31'd0, memReq}, 32'd1);
`endif
    reset = 1'b1;
    #1;
    check("final reset memError", {31'd0, memError}, 32'd0);
    check("final reset stall", {31'd0, stall}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
